// File: rtl/mips_mem_defs.sv
// Shared definitions for the memory-side DMA engine.
// State encoding, mode values and the default address width.
package mips_mem_defs;

  localparam int ADDR_WIDTH_DEF = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_COPY_RD = 2'd2,
    ST_COPY_WR = 2'd3
  } state_t;

  localparam logic MODE_FILL = 1'b0;
  localparam logic MODE_COPY = 1'b1;

endpackage

// File: rtl/dma_addr_gen.sv
// Offset counter, src/dst adders and fill accumulator.
// Exposes next-cycle values so the top can register its outputs.
module dma_addr_gen
  import mips_mem_defs::*;
#(
  parameter int AW = ADDR_WIDTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  input  logic [31:0]   base,
  input  logic [31:0]   inc,
  output logic [AW-1:0] raddr_n,
  output logic [AW-1:0] waddr_n,
  output logic [31:0]   fill_n,
  output logic          last
);

  logic [AW-1:0] src_q, dst_q, len_q, off_q, off_n;
  logic [31:0]   acc_q, inc_q;

  always_comb begin
    off_n  = off_q;
    fill_n = acc_q;
    if (load) begin
      off_n  = '0;
      fill_n = base;
    end else if (step) begin
      off_n  = off_q + 1'b1;
      fill_n = acc_q + inc_q;
    end
  end

  // Address sums wrap naturally at 2^AW.
  assign raddr_n = (load ? src : src_q) + off_n;
  assign waddr_n = (load ? dst : dst_q) + off_n;
  assign last    = (off_q == len_q - 1'b1);

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
      inc_q <= '0;
      off_q <= '0;
      acc_q <= '0;
    end else begin
      if (load) begin
        src_q <= src;
        dst_q <= dst;
        len_q <= len;
        inc_q <= inc;
      end
      off_q <= off_n;
      acc_q <= fill_n;
    end
  end

endmodule

// File: rtl/mem_dma_engine.sv
// FILL / COPY block engine on the ideal memory ports.
// Outputs are registered from next-state values.
module mem_dma_engine
  import mips_mem_defs::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH-1:0] len,
  input  logic [31:0]           fill_base,
  input  logic [31:0]           fill_step,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] words_done,
  output logic [ADDR_WIDTH-1:0] Waddr,
  output logic                  Wren,
  output logic [31:0]           Wdata,
  output logic [ADDR_WIDTH-1:0] Raddr1,
  output logic                  Rden1,
  input  logic [31:0]           Rdata1
);

  state_t state, state_n;
  logic load, step, done_n, wr_now, wr_n, rd_n, last;
  logic [ADDR_WIDTH-1:0] raddr_n, waddr_n;
  logic [31:0] fill_n, data_q, data_n;

  dma_addr_gen #(.AW(ADDR_WIDTH)) u_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .step    (step),
    .src     (src_addr),
    .dst     (dst_addr),
    .len     (len),
    .base    (fill_base),
    .inc     (fill_step),
    .raddr_n (raddr_n),
    .waddr_n (waddr_n),
    .fill_n  (fill_n),
    .last    (last)
  );

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    done_n  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          load = 1'b1;
          if (len == '0) done_n = 1'b1;
          else if (mode == MODE_COPY) state_n = ST_COPY_RD;
          else state_n = ST_FILL;
        end
      end
      ST_FILL: begin
        if (abort) state_n = ST_IDLE;
        else if (last) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end else step = 1'b1;
      end
      ST_COPY_RD: begin
        if (abort) state_n = ST_IDLE;
        else state_n = ST_COPY_WR;
      end
      ST_COPY_WR: begin
        if (abort) state_n = ST_IDLE;
        else if (last) begin
          state_n = ST_IDLE;
          done_n  = 1'b1;
        end else begin
          step    = 1'b1;
          state_n = ST_COPY_RD;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // A write already on the bus this cycle always completes.
  assign wr_now = (state == ST_FILL) || (state == ST_COPY_WR);
  assign wr_n   = (state_n == ST_FILL) || (state_n == ST_COPY_WR);
  assign rd_n   = (state_n == ST_COPY_RD);
  assign data_n = (state == ST_COPY_RD) ? Rdata1 : data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      words_done <= '0;
      data_q     <= '0;
      Wren       <= 1'b0;
      Waddr      <= '0;
      Wdata      <= '0;
      Rden1      <= 1'b0;
      Raddr1     <= '0;
    end else begin
      state <= state_n;
      busy  <= (state_n != ST_IDLE);
      done  <= done_n;
      if (load) words_done <= '0;
      else if (wr_now) words_done <= words_done + 1'b1;
      data_q <= load ? '0 : data_n;
      Wren   <= wr_n;
      Waddr  <= wr_n ? waddr_n : '0;
      if (state_n == ST_FILL) Wdata <= fill_n;
      else if (state_n == ST_COPY_WR) Wdata <= data_n;
      else Wdata <= '0;
      Rden1  <= rd_n;
      Raddr1 <= rd_n ? raddr_n : '0;
    end
  end

endmodule
